// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The fetch unit is the master; the memory (or a bench model) is the slave.
interface fetch_unit_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_rdata,
    output imem_resp
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, runs the imem handshake and
// holds one fetched instruction for decode, squashing wrong-path fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_en,
  input  logic                pcmux_sel,
  input  logic [31:0]         br_target,
  fetch_unit_if.master        imem,
  input  logic                id_stall,
  output logic                if_valid,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_instr,
  output logic                fetch_busy
);

  localparam logic PCMUX_ALU_OUT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] target_reg;
  logic        valid_reg;
  logic [31:0] if_pc_reg;
  logic [31:0] instr_reg;

  logic redirect;
  logic slot_free;

  assign redirect  = (pcmux_sel == PCMUX_ALU_OUT);
  assign slot_free = !valid_reg || !id_stall;

  // Request strobe and address come straight from state/PC registers, so they
  // stay stable for the whole life of a request.
  assign imem.imem_read    = (state_reg != IDLE);
  assign imem.imem_address = pc_reg;
  assign fetch_busy        = (state_reg != IDLE);
  assign if_valid          = valid_reg;
  assign if_pc             = if_pc_reg;
  assign if_instr          = instr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      target_reg <= 32'h0;
      valid_reg  <= 1'b0;
      if_pc_reg  <= 32'h0;
      instr_reg  <= 32'h0;
    end else begin
      // Accept by decode; a fill or redirect below overrides this.
      if (valid_reg && !id_stall) begin
        valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (redirect) begin
            pc_reg    <= br_target;
            valid_reg <= 1'b0;
          end else if (pc_en && slot_free) begin
            state_reg <= BUSY;
          end
        end

        BUSY: begin
          if (imem.imem_resp && !redirect) begin
            instr_reg <= imem.imem_rdata;
            if_pc_reg <= pc_reg;
            valid_reg <= 1'b1;
            pc_reg    <= pc_reg + 32'd4;
            state_reg <= IDLE;
          end else if (imem.imem_resp) begin
            pc_reg    <= br_target;
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end else if (redirect) begin
            target_reg <= br_target;
            valid_reg  <= 1'b0;
            state_reg  <= DRAIN;
          end
        end

        DRAIN: begin
          // The squashed request must complete before the new PC is used.
          if (redirect) begin
            target_reg <= br_target;
            valid_reg  <= 1'b0;
          end
          if (imem.imem_resp) begin
            pc_reg    <= redirect ? br_target : target_reg;
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays imem and decode, then checks
// PC sequencing, redirect squashing, stall back-pressure and reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pc_en;
  logic        pcmux_sel;
  logic [31:0] br_target;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_busy;

  int checks;
  int errors;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h6000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_en      (pc_en),
    .pcmux_sel  (pcmux_sel),
    .br_target  (br_target),
    .imem       (bus.master),
    .id_stall   (id_stall),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .fetch_busy (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
    $display("check %-14s observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    pc_en = 1'b0;
    pcmux_sel = 1'b0;
    br_target = 32'h0;
    id_stall = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.imem_resp = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_read", 32'(bus.imem_read), 32'd0);
    check("rst_addr", bus.imem_address, 32'h6000_0000);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_busy", 32'(fetch_busy), 32'd0);

    // 1. First request one cycle after enabling
    pc_en = 1'b1;
    tick();
    check("t1_read", 32'(bus.imem_read), 32'd1);
    check("t1_addr", bus.imem_address, 32'h6000_0000);

    // 2. Response two cycles after request
    tick();
    check("t2_wait_read", 32'(bus.imem_read), 32'd1);
    bus.imem_resp = 1'b1;
    bus.imem_rdata = 32'h0000_0013;
    tick();
    bus.imem_resp = 1'b0;
    check("t2_valid", 32'(if_valid), 32'd1);
    check("t2_pc", if_pc, 32'h6000_0000);
    check("t2_instr", if_instr, 32'h0000_0013);
    check("t2_idle_read", 32'(bus.imem_read), 32'd0);
    tick();
    check("t2_next_read", 32'(bus.imem_read), 32'd1);
    check("t2_next_addr", bus.imem_address, 32'h6000_0004);
    check("t2_accepted", 32'(if_valid), 32'd0);

    // 3. Redirect while BUSY without response -> DRAIN
    pcmux_sel = 1'b1;
    br_target = 32'h6000_0100;
    tick();
    pcmux_sel = 1'b0;
    check("t3_drain_read", 32'(bus.imem_read), 32'd1);
    check("t3_drain_addr", bus.imem_address, 32'h6000_0004);
    tick();
    check("t3_hold_addr", bus.imem_address, 32'h6000_0004);
    bus.imem_resp = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_resp = 1'b0;
    check("t3_drop_valid", 32'(if_valid), 32'd0);
    check("t3_idle_read", 32'(bus.imem_read), 32'd0);
    tick();
    check("t3_new_read", 32'(bus.imem_read), 32'd1);
    check("t3_new_addr", bus.imem_address, 32'h6000_0100);

    // 4. Redirect coincident with response
    bus.imem_resp = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    pcmux_sel = 1'b1;
    br_target = 32'h6000_0200;
    tick();
    bus.imem_resp = 1'b0;
    pcmux_sel = 1'b0;
    check("t4_no_fill", 32'(if_valid), 32'd0);
    check("t4_instr_kept", if_instr, 32'h0000_0013);
    tick();
    check("t4_new_read", 32'(bus.imem_read), 32'd1);
    check("t4_new_addr", bus.imem_address, 32'h6000_0200);

    // 5. Stalled slot blocks new requests
    bus.imem_resp = 1'b1;
    bus.imem_rdata = 32'h0010_0093;
    id_stall = 1'b1;
    tick();
    bus.imem_resp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t5_stall_read", 32'(bus.imem_read), 32'd0);
      check("t5_stall_valid", 32'(if_valid), 32'd1);
      check("t5_stall_pc", if_pc, 32'h6000_0200);
      check("t5_stall_instr", if_instr, 32'h0010_0093);
      tick();
    end
    id_stall = 1'b0;
    tick();
    check("t5_accept", 32'(if_valid), 32'd0);
    check("t5_req_read", 32'(bus.imem_read), 32'd1);
    check("t5_req_addr", bus.imem_address, 32'h6000_0204);
    bus.imem_resp = 1'b1;
    bus.imem_rdata = 32'h0020_8113;
    tick();
    bus.imem_resp = 1'b0;
    check("t5_fill_pc", if_pc, 32'h6000_0204);
    check("t5_fill_instr", if_instr, 32'h0020_8113);

    // 6. pc_en low in IDLE blocks requests; low in BUSY does not abort
    pc_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_blocked", 32'(bus.imem_read), 32'd0);
    end
    check("t6_drained", 32'(if_valid), 32'd0);
    pc_en = 1'b1;
    tick();
    check("t6_req_addr", bus.imem_address, 32'h6000_0208);
    pc_en = 1'b0;
    tick();
    check("t6_busy_hold", 32'(bus.imem_read), 32'd1);
    bus.imem_resp = 1'b1;
    bus.imem_rdata = 32'h0031_0193;
    tick();
    bus.imem_resp = 1'b0;
    check("t6_fill_valid", 32'(if_valid), 32'd1);
    check("t6_fill_pc", if_pc, 32'h6000_0208);
    check("t6_fill_instr", if_instr, 32'h0031_0193);

    // Redirect in IDLE with pc_en low clears a stalled slot
    id_stall = 1'b1;
    pcmux_sel = 1'b1;
    br_target = 32'h6000_0300;
    tick();
    pcmux_sel = 1'b0;
    id_stall = 1'b0;
    check("rd_idle_valid", 32'(if_valid), 32'd0);
    check("rd_idle_addr", bus.imem_address, 32'h6000_0300);
    check("rd_idle_read", 32'(bus.imem_read), 32'd0);

    // DRAIN: latest redirect wins
    pc_en = 1'b1;
    tick();
    pcmux_sel = 1'b1;
    br_target = 32'h6000_0400;
    tick();
    br_target = 32'h6000_0500;
    tick();
    pcmux_sel = 1'b0;
    check("dr_addr_hold", bus.imem_address, 32'h6000_0300);
    bus.imem_resp = 1'b1;
    pc_en = 1'b0;
    tick();
    bus.imem_resp = 1'b0;
    check("dr_latest", bus.imem_address, 32'h6000_0500);
    check("dr_valid", 32'(if_valid), 32'd0);

    // Stray response in IDLE ignored
    bus.imem_resp = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    tick();
    bus.imem_resp = 1'b0;
    check("stray_valid", 32'(if_valid), 32'd0);
    check("stray_addr", bus.imem_address, 32'h6000_0500);

    // Reset mid-request
    pc_en = 1'b1;
    tick();
    check("mid_read", 32'(bus.imem_read), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pc_en = 1'b0;
    check("mid_rst_read", 32'(bus.imem_read), 32'd0);
    check("mid_rst_addr", bus.imem_address, 32'h6000_0000);

    // PC wraps modulo 2^32
    pcmux_sel = 1'b1;
    br_target = 32'hFFFF_FFFC;
    tick();
    pcmux_sel = 1'b0;
    pc_en = 1'b1;
    tick();
    check("wrap_addr", bus.imem_address, 32'hFFFF_FFFC);
    bus.imem_resp = 1'b1;
    bus.imem_rdata = 32'h0000_006F;
    tick();
    bus.imem_resp = 1'b0;
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_next", bus.imem_address, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
